// File: rtl/terrain_level_loader.sv
// Level loader for the terrain entity bank: clears all terrain entities, then walks one
// level's entries in an external synchronous ROM and issues one spawn pulse per entry.
package terrain_level_loader_pkg;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } point_t;

    typedef struct packed {
        point_t center;
        point_t radius;
    } rect_t;
endpackage

module terrain_level_loader
    import terrain_level_loader_pkg::*;
#(
    parameter int MAX_ENTRIES = 64,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              loadStart,
    input  logic              loadAbort,
    input  logic [1:0]        levelSel,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [48:0]       romData,
    output logic              sigKill,
    output logic              sigSpawn,
    output logic [7:0]        terrainID,
    output rect_t             spawnArea,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        spawnCount
);
    localparam int IDX_W = $clog2(MAX_ENTRIES);

    typedef enum logic [2:0] {IDLE, KILL, FETCH, CHECK, SPAWN, DONE} state_t;

    state_t            state, nextState;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  fetchIdx;
    logic              endMarker;
    logic              lastSlot;

    assign endMarker = romData[48];
    assign lastSlot  = (idx == IDX_W'(MAX_ENTRIES - 1));
    // Leaving SPAWN the next fetch must already use the incremented slot.
    assign fetchIdx  = (state == SPAWN) ? idx + IDX_W'(1) : idx;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (loadStart) nextState = KILL;
            KILL:    nextState = FETCH;
            FETCH:   nextState = CHECK;
            CHECK:   nextState = endMarker ? DONE : SPAWN;
            SPAWN:   nextState = lastSlot ? DONE : FETCH;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        // Abort outranks every transition; in IDLE it also swallows a coincident loadStart.
        if (loadAbort) nextState = IDLE;
    end

    // Outputs are decoded from nextState so each pulse lines up with the state it belongs to.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            base       <= '0;
            idx        <= '0;
            romAddr    <= '0;
            sigKill    <= 1'b0;
            sigSpawn   <= 1'b0;
            terrainID  <= '0;
            spawnArea  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            spawnCount <= '0;
        end else begin
            state    <= nextState;
            sigKill  <= (nextState == KILL);
            sigSpawn <= (nextState == SPAWN);
            done     <= (nextState == DONE);
            busy     <= (nextState == KILL) || (nextState == FETCH) ||
                        (nextState == CHECK) || (nextState == SPAWN);

            if (nextState == KILL) begin
                base       <= ADDR_W'(levelSel) << IDX_W;
                idx        <= '0;
                spawnCount <= '0;
                overflow   <= 1'b0;
            end

            if (nextState == FETCH)
                romAddr <= base + ADDR_W'(fetchIdx);

            if (state == CHECK && nextState == SPAWN) begin
                terrainID <= romData[47:40];
                spawnArea <= rect_t'(romData[39:0]);
            end

            if (nextState == SPAWN && spawnCount != 8'hFF)
                spawnCount <= spawnCount + 8'd1;

            if (state == SPAWN && !lastSlot)
                idx <= idx + IDX_W'(1);

            if (state == SPAWN && nextState == DONE)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_terrain_level_loader.sv
// Randomized self-checking bench for terrain_level_loader: a behavioural ROM plus a per-load
// event model (spawn/fetch/done cycles derived from the level contents) checked every cycle.
module tb_terrain_level_loader;
    import terrain_level_loader_pkg::*;

    localparam int MAX_ENTRIES = 64;
    localparam int ADDR_W      = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              loadStart = 1'b0;
    logic              loadAbort = 1'b0;
    logic [1:0]        levelSel = 2'd0;
    logic [ADDR_W-1:0] romAddr;
    logic [48:0]       romData = '0;
    logic              sigKill, sigSpawn, busy, done, overflow;
    logic [7:0]        terrainID, spawnCount;
    rect_t             spawnArea;

    int checks = 0;
    int errors = 0;
    int expRomAddr = 0;
    logic [48:0] rom [256];

    terrain_level_loader #(.MAX_ENTRIES(MAX_ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .loadStart(loadStart), .loadAbort(loadAbort),
        .levelSel(levelSel), .romAddr(romAddr), .romData(romData), .sigKill(sigKill),
        .sigSpawn(sigSpawn), .terrainID(terrainID), .spawnArea(spawnArea), .busy(busy),
        .done(done), .overflow(overflow), .spawnCount(spawnCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) romData <= rom[romAddr];

    function automatic logic [48:0] entry(input int id, input int cx, input int cy,
                                          input int rx, input int ry);
        return {1'b0, 8'(id), 10'(cx), 10'(cy), 10'(rx), 10'(ry)};
    endfunction

    function automatic logic [48:0] randEntry();
        return {1'b0, 8'($urandom), 40'({$urandom, $urandom})};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".romAddr"}, 64'(romAddr), 0);
        check({tag, ".flags"}, 64'({sigKill, sigSpawn, busy, done, overflow}), 0);
        check({tag, ".terrainID"}, 64'(terrainID), 0);
        check({tag, ".spawnArea"}, 64'(spawnArea), 0);
        check({tag, ".spawnCount"}, 64'(spawnCount), 0);
    endtask

    // One load with loadStart at cycle 0. abortCycle/restartCycle of 0 mean "not used".
    task automatic runLoad(input string name, input int level, input int abortCycle,
                           input int restartCycle);
        int base, n, doneCycle, limit, expCount, k;
        bit ovf, aborted, expSpawn, expOvf;
        string t;
        base = level * MAX_ENTRIES;
        n = 0;
        ovf = 1'b1;
        for (int s = 0; s < MAX_ENTRIES; s++) begin
            if (rom[base + s][48]) begin
                ovf = 1'b0;
                break;
            end
            n++;
        end
        doneCycle = ovf ? 3 * n + 2 : 3 * n + 4;
        limit = (abortCycle > 0) ? abortCycle + 5 : doneCycle + 2;
        expCount = 0;
        expOvf = 1'b0;

        @(negedge clk);
        levelSel = 2'(level);
        loadStart = 1'b1;
        @(posedge clk);
        #1 loadStart = 1'b0;
        levelSel = 2'($urandom);

        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            aborted = (abortCycle > 0) && (c > abortCycle);
            expSpawn = !aborted && c >= 4 && (c - 4) % 3 == 0 && (c - 4) / 3 < n;
            if (expSpawn) expCount++;
            if (!aborted && c >= 2 && c < doneCycle && (c - 2) % 3 == 0)
                expRomAddr = base + (c - 2) / 3;
            if (!aborted && c == doneCycle && ovf) expOvf = 1'b1;
            t = $sformatf("%s.c%0d", name, c);
            check({t, ".sigKill"}, 64'(sigKill), 64'(!aborted && c == 1));
            check({t, ".sigSpawn"}, 64'(sigSpawn), 64'(expSpawn));
            check({t, ".done"}, 64'(done), 64'(!aborted && c == doneCycle));
            check({t, ".busy"}, 64'(busy), 64'(!aborted && c >= 1 && c < doneCycle));
            check({t, ".romAddr"}, 64'(romAddr), 64'(expRomAddr));
            check({t, ".spawnCount"}, 64'(spawnCount), 64'(expCount));
            check({t, ".overflow"}, 64'(overflow), 64'(expOvf));
            if (expSpawn) begin
                k = (c - 4) / 3;
                check({t, ".terrainID"}, 64'(terrainID), 64'(rom[base + k][47:40]));
                check({t, ".spawnArea"}, 64'(spawnArea), 64'(rom[base + k][39:0]));
            end
            loadAbort = (c == abortCycle);
            loadStart = (c == restartCycle);
        end
        loadAbort = 1'b0;
        loadStart = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = randEntry();
        rom[0] = entry(3, 100, 200, 16, 16);
        rom[1] = entry(5, 40, 40, 8, 8);
        rom[2] = {1'b1, 48'h0};
        rom[128] = {1'b1, 48'($urandom)};

        #2 reset_n = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        runLoad("level0", 0, 0, 0);
        check("level0.finalCount", 64'(spawnCount), 2);
        runLoad("empty", 2, 0, 0);
        check("empty.romAddr", 64'(romAddr), 128);
        runLoad("full", 1, 0, 0);
        check("full.finalAddr", 64'(romAddr), 127);
        check("full.overflow", 64'(overflow), 1);
        runLoad("restart", 0, 0, 5);
        runLoad("abort5", 0, 5, 0);
        check("abort5.count", 64'(spawnCount), 1);
        runLoad("abortSpawn", 0, 7, 0);

        // Asynchronous reset in the middle of a CHECK cycle.
        @(negedge clk);
        levelSel = 2'd0;
        loadStart = 1'b1;
        @(posedge clk);
        #1 loadStart = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 checkAllZero("midReset");
        expRomAddr = 0;
        @(negedge clk);
        reset_n = 1'b1;
        runLoad("afterReset", 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            int len, ab;
            len = $urandom_range(0, 10);
            for (int s = 0; s < MAX_ENTRIES; s++) rom[192 + s] = randEntry();
            rom[192 + len] = {1'b1, 48'($urandom)};
            ab = (r % 2 == 1 && len > 0) ? 4 + 3 * $urandom_range(0, len - 1) : 0;
            runLoad($sformatf("rand%0d", r), 3, ab, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
